// File: rtl/flop_bank_pkg.sv
// Shared encodings for the flop bank driver: command ops, FSM states, default width.
package flop_bank_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_SET   = 2'b10,
    OP_CHECK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DRIVE  = 2'b01,
    S_VERIFY = 2'b10
  } state_e;

endpackage

// File: rtl/flop_bank_driver_if.sv
// Command handshake between a requester (master) and the flop bank driver (slave).
interface flop_bank_driver_if
  import flop_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/flop_bank_driver.sv
// Drives sync reset/preset/data into an external flop bank, then reads it back
// and compares against an internal model, flagging and counting mismatches.
module flop_bank_driver
  import flop_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  flop_bank_driver_if.slave   cmd,
  output logic                bank_reset,
  output logic                bank_preset,
  output logic [WIDTH-1:0]    bank_d,
  input  logic [WIDTH-1:0]    bank_q,
  output logic [WIDTH-1:0]    expected,
  output logic                done,
  output logic                err,
  output logic [7:0]          err_count
);

  state_e state;

  function automatic logic [WIDTH-1:0] next_expected(
    input op_e              op,
    input logic [WIDTH-1:0] data,
    input logic [WIDTH-1:0] cur
  );
    logic [WIDTH-1:0] r;
    r = cur;
    unique case (op)
      OP_LOAD:  r = data;
      OP_CLEAR: r = '0;
      OP_SET:   r = '1;
      OP_CHECK: r = cur;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_COUNT_MAX) ? v : v + 8'd1;
  endfunction

  // The bank's data input always mirrors the model, so an idle bank keeps its value.
  assign bank_d = expected;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bank_reset    <= 1'b1;
      bank_preset   <= 1'b0;
      expected      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_count     <= '0;
      cmd.cmd_ready <= 1'b0;
    end else begin
      bank_reset  <= 1'b0;
      bank_preset <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cmd.cmd_ready <= 1'b1;
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            state         <= S_DRIVE;
            cmd.cmd_ready <= 1'b0;
            expected      <= next_expected(cmd.cmd_op, cmd.cmd_data, expected);
            bank_reset    <= (cmd.cmd_op == OP_CLEAR);
            bank_preset   <= (cmd.cmd_op == OP_SET);
          end
        end
        S_DRIVE: begin
          state <= S_VERIFY;
        end
        S_VERIFY: begin
          // Bank captured the drive on the previous edge, so bank_q is settled here.
          state         <= S_IDLE;
          done          <= 1'b1;
          cmd.cmd_ready <= 1'b1;
          if (bank_q != expected) begin
            err       <= 1'b1;
            err_count <= sat_inc(err_count);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flop_bank_driver.sv
// Scoreboard bench for flop_bank_driver with a behavioural flop bank on bank_*.
module tb_flop_bank_driver;
  import flop_bank_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             bank_reset, bank_preset, done, err;
  logic [WIDTH-1:0] bank_d, bank_q, expected, flops;
  logic [WIDTH-1:0] force_mask;
  logic [7:0]       err_count;

  flop_bank_driver_if #(.WIDTH(WIDTH)) cmd ();

  flop_bank_driver #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd.slave),
    .bank_reset  (bank_reset),
    .bank_preset (bank_preset),
    .bank_d      (bank_d),
    .bank_q      (bank_q),
    .expected    (expected),
    .done        (done),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Flop bank: sync reset over sync preset over d; bench can force bits high.
  always_ff @(posedge clk) begin
    if (bank_reset)       flops <= '0;
    else if (bank_preset) flops <= '1;
    else                  flops <= bank_d;
  end
  assign bank_q = flops | force_mask;

  typedef struct {
    logic [WIDTH-1:0] exp;
    logic             err;
    logic [7:0]       cnt;
  } sb_t;

  sb_t              sbq[$];
  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] exp_m = '0;
  logic             err_m = 1'b0;
  logic [7:0]       cnt_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input op_e op, input logic [WIDTH-1:0] data);
    sb_t e;
    case (op)
      OP_LOAD:  exp_m = data;
      OP_CLEAR: exp_m = '0;
      OP_SET:   exp_m = '1;
      default:  exp_m = exp_m;
    endcase
    if ((exp_m | force_mask) != exp_m) begin
      err_m = 1'b1;
      if (cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
    end
    e.exp = exp_m;
    e.err = err_m;
    e.cnt = cnt_m;
    sbq.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd.cmd_ready) chk("ready_timeout", 32'(cmd.cmd_ready), 32'd1);
  endtask

  // Returns #1 after the accept edge.
  task automatic send(input op_e op, input logic [WIDTH-1:0] data);
    wait_ready();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_data  = data;
    push_model(op, data);
    tick();
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, want no pulse");
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_expected", 32'(expected), 32'(e.exp));
        chk("sb_bank_d", 32'(bank_d), 32'(e.exp));
        chk("sb_err", 32'(err), 32'(e.err));
        chk("sb_err_count", 32'(err_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    force_mask    = '0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_LOAD;
    cmd.cmd_data  = '0;

    // Reset state after two held edges
    tick(); tick();
    chk("rst_bank_reset", 32'(bank_reset), 32'd1);
    chk("rst_bank_preset", 32'(bank_preset), 32'd0);
    chk("rst_bank_d", 32'(bank_d), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_ready", 32'(cmd.cmd_ready), 32'd0);
    reset = 1'b0;
    chk("rel_bank_reset_held", 32'(bank_reset), 32'd1);
    tick();
    chk("rel_bank_reset", 32'(bank_reset), 32'd0);
    chk("rel_ready", 32'(cmd.cmd_ready), 32'd1);
    chk("rel_bank_q", 32'(bank_q), 32'h00);

    // LOAD 0xA5 timing
    send(OP_LOAD, 8'hA5);
    chk("load_bank_d", 32'(bank_d), 32'hA5);
    chk("load_ready_low", 32'(cmd.cmd_ready), 32'd0);
    chk("load_done_e1", 32'(done), 32'd0);
    tick();
    chk("load_bank_q", 32'(bank_q), 32'hA5);
    chk("load_done_e2", 32'(done), 32'd0);
    tick();
    chk("load_done_pulse", 32'(done), 32'd1);
    chk("load_err", 32'(err), 32'd0);
    tick();
    chk("load_done_end", 32'(done), 32'd0);

    // SET then CLEAR back-to-back with cmd_valid held
    wait_ready();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = OP_SET;
    push_model(OP_SET, '0);
    tick();
    chk("b2b_preset", 32'(bank_preset), 32'd1);
    chk("b2b_no_reset", 32'(bank_reset), 32'd0);
    cmd.cmd_op = OP_CLEAR;
    push_model(OP_CLEAR, '0);
    tick();
    chk("b2b_q_ff", 32'(bank_q), 32'hFF);
    chk("b2b_preset_off", 32'(bank_preset), 32'd0);
    tick();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_reset_not_yet", 32'(bank_reset), 32'd0);
    tick();
    chk("b2b_reset", 32'(bank_reset), 32'd1);
    chk("b2b_no_preset", 32'(bank_preset), 32'd0);
    cmd.cmd_valid = 1'b0;
    tick();
    chk("b2b_q_00", 32'(bank_q), 32'h00);
    tick();
    chk("b2b_done2", 32'(done), 32'd1);
    drain();

    // cmd_valid during VERIFY is ignored
    send(OP_LOAD, 8'h22);
    tick();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = OP_LOAD;
    cmd.cmd_data  = 8'h11;
    tick();
    cmd.cmd_valid = 1'b0;
    chk("ign_expected", 32'(expected), 32'h22);
    tick();
    chk("ign_expected_after", 32'(expected), 32'h22);
    chk("ign_no_accept", 32'(cmd.cmd_ready), 32'd1);
    drain();

    // Forced mismatch and saturation
    send(OP_LOAD, 8'h3C);
    drain();
    force_mask = 8'h01;
    send(OP_CHECK, '0);
    drain();
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_count", 32'(err_count), 32'd1);
    for (int i = 0; i < 300; i++) send(OP_CHECK, '0);
    drain();
    chk("sat_count", 32'(err_count), 32'd255);
    force_mask = '0;
    send(OP_CHECK, '0);
    drain();
    chk("sticky_err", 32'(err), 32'd1);
    chk("sticky_count", 32'(err_count), 32'd255);

    // Reset during DRIVE of SET aborts the command
    send(OP_SET, '0);
    void'(sbq.pop_back());
    exp_m = '0;
    err_m = 1'b0;
    cnt_m = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_bank_reset", 32'(bank_reset), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_expected", 32'(expected), 32'h00);
    tick();
    chk("abort_bank_q", 32'(bank_q), 32'h00);
    chk("abort_err", 32'(err), 32'd0);
    tick(); tick();
    chk("abort_done_late", 32'(done), 32'd0);

    send(OP_CHECK, '0);
    drain();
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
